// File: rtl/nba_seq_ctrl.sv
// Three-state sequencer: a bitwise a/b/c/d update runs for a latched number of steps.
// Define NBA_SEQ_BLOCKING_EN to chain each step's updates in order instead of in parallel.
module nba_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] c_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic [CNT_W-1:0] steps,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] c_out,
  output logic [WIDTH-1:0] d_out,
  output logic [CNT_W-1:0] step_cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [WIDTH-1:0] r_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_steps;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_c;
  logic [WIDTH-1:0] w_d;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_last;

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_last    = (r_cnt == (r_steps - CNT_W'(1)));

`ifdef NBA_SEQ_BLOCKING_EN
  // d and c see the freshly computed a within the same step
  always_comb begin
    w_a = r_b & r_c;
    w_d = w_a ^ r_d;
    w_c = w_a | r_b;
  end
`else
  always_comb begin
    w_a = r_b & r_c;
    w_d = r_a ^ r_d;
    w_c = r_a | r_b;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_steps <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_c     <= c_in;
            r_d     <= d_in;
            r_steps <= steps;
            r_cnt   <= '0;
            r_state <= (steps == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // abort takes priority, even over the final step
          if (abort) begin
            r_state <= IDLE;
          end else begin
            r_a   <= w_a;
            r_c   <= w_c;
            r_d   <= w_d;
            r_cnt <= w_cnt_inc;
            if (w_last) r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign a_out    = r_a;
  assign b_out    = r_b;
  assign c_out    = r_c;
  assign d_out    = r_d;
  assign step_cnt = r_cnt;
  assign busy     = (r_state == RUN);
  assign done     = (r_state == DONE);

endmodule

// File: tb/tb_nba_seq_ctrl.sv
// Directed bench for nba_seq_ctrl; expected values are hand-computed.
// Honours NBA_SEQ_BLOCKING_EN when picking expected step results.
module tb_nba_seq_ctrl;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] c_in;
  logic [WIDTH-1:0] d_in;
  logic [CNT_W-1:0] steps;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [WIDTH-1:0] c_out;
  logic [WIDTH-1:0] d_out;
  logic [CNT_W-1:0] step_cnt;
  logic             busy;
  logic             done;

  int n_cmp;
  int n_err;
  int n_done;
  int n_busy;
  int base;

  nba_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .a_in     (a_in),
    .b_in     (b_in),
    .c_in     (c_in),
    .d_in     (d_in),
    .steps    (steps),
    .a_out    (a_out),
    .b_out    (b_out),
    .c_out    (c_out),
    .d_out    (d_out),
    .step_cnt (step_cnt),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) n_done++;
    if (busy) n_busy++;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input int ea, input int eb,
                          input int ec, input int ed);
    chk({tag, ".a"}, 64'(a_out), 64'(ea));
    chk({tag, ".b"}, 64'(b_out), 64'(eb));
    chk({tag, ".c"}, 64'(c_out), 64'(ec));
    chk({tag, ".d"}, 64'(d_out), 64'(ed));
  endtask

  task automatic chk_ctl(input string tag, input int ecnt, input bit ebusy,
                         input bit edone);
    chk({tag, ".cnt"},  64'(step_cnt), 64'(ecnt));
    chk({tag, ".busy"}, 64'(busy),     64'(ebusy));
    chk({tag, ".done"}, 64'(done),     64'(edone));
  endtask

  task automatic set_ops(input int a, input int b, input int c, input int d,
                         input int n);
    a_in  = WIDTH'(a);
    b_in  = WIDTH'(b);
    c_in  = WIDTH'(c);
    d_in  = WIDTH'(d);
    steps = CNT_W'(n);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    n_done = 0;
    n_busy = 0;
    rst    = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    set_ops(0, 0, 0, 0, 0);

    tick();
    chk_regs("rst", 0, 0, 0, 0);
    chk_ctl("rst", 0, 0, 0);
    rst = 1'b0;
    tick();

    // three-step run, operands scrambled after capture
    base = n_done;
    set_ops(30, 20, 15, 5, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    set_ops(7, 7, 7, 7, 9);
    chk_regs("r3.load", 30, 20, 15, 5);
    chk_ctl("r3.load", 0, 1, 0);
    tick();
`ifdef NBA_SEQ_BLOCKING_EN
    chk_regs("r3.s1", 4, 20, 20, 1);
`else
    chk_regs("r3.s1", 4, 20, 30, 27);
`endif
    chk_ctl("r3.s1", 1, 1, 0);
    tick();
`ifdef NBA_SEQ_BLOCKING_EN
    chk_regs("r3.s2", 20, 20, 20, 21);
`else
    chk_regs("r3.s2", 20, 20, 20, 31);
`endif
    chk_ctl("r3.s2", 2, 1, 0);
    tick();
`ifdef NBA_SEQ_BLOCKING_EN
    chk_regs("r3.s3", 20, 20, 20, 1);
`else
    chk_regs("r3.s3", 20, 20, 20, 11);
`endif
    chk_ctl("r3.s3", 3, 0, 1);
    tick();
`ifdef NBA_SEQ_BLOCKING_EN
    chk_regs("r3.idle", 20, 20, 20, 1);
`else
    chk_regs("r3.idle", 20, 20, 20, 11);
`endif
    chk_ctl("r3.idle", 3, 0, 0);
    chk("r3.ndone", 64'(n_done - base), 64'd1);

    // single step: the build-dependent ordering shows up directly
    set_ops(30, 20, 15, 5, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_ctl("r1.load", 0, 1, 0);
    tick();
`ifdef NBA_SEQ_BLOCKING_EN
    chk_regs("r1.s1", 4, 20, 20, 1);
`else
    chk_regs("r1.s1", 4, 20, 30, 27);
`endif
    chk_ctl("r1.s1", 1, 0, 1);
    tick();

    // zero steps: done on the start edge, never busy
    base = n_busy;
    set_ops(30, 20, 15, 5, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_regs("r0", 30, 20, 15, 5);
    chk_ctl("r0", 0, 0, 1);
    tick();
    chk_ctl("r0.idle", 0, 0, 0);
    chk("r0.nbusy", 64'(n_busy - base), 64'd0);

    // abort seen on the edge of step 3
    base = n_done;
    set_ops(30, 20, 15, 5, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
`ifdef NBA_SEQ_BLOCKING_EN
    chk_regs("ab", 20, 20, 20, 21);
`else
    chk_regs("ab", 20, 20, 20, 31);
`endif
    chk_ctl("ab", 2, 0, 0);
    tick();
    tick();
    chk_ctl("ab.hold", 2, 0, 0);
    chk("ab.ndone", 64'(n_done - base), 64'd0);

    // start held high across the whole run
    base = n_done;
    set_ops(30, 20, 15, 5, 2);
    start = 1'b1;
    tick();
    set_ops(1, 2, 3, 4, 2);
    chk_ctl("sh.e0", 0, 1, 0);
    tick();
    chk_ctl("sh.e1", 1, 1, 0);
    tick();
    chk_ctl("sh.e2", 2, 0, 1);
    tick();
    chk_ctl("sh.e3", 2, 0, 0);
`ifdef NBA_SEQ_BLOCKING_EN
    chk_regs("sh.e3", 20, 20, 20, 21);
`else
    chk_regs("sh.e3", 20, 20, 20, 31);
`endif
    tick();
    start = 1'b0;
    chk_regs("sh.e4", 1, 2, 3, 4);
    chk_ctl("sh.e4", 0, 1, 0);
    chk("sh.ndone", 64'(n_done - base), 64'd1);
    tick();
    tick();
    chk_ctl("sh.e6", 2, 0, 1);
    tick();

    // asynchronous reset between edges, mid-run
    set_ops(30, 20, 15, 5, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_ctl("ar.pre", 1, 1, 0);
    #1 rst = 1'b1;
    #1;
    chk_regs("ar.async", 0, 0, 0, 0);
    chk_ctl("ar.async", 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    chk_regs("ar.rel", 0, 0, 0, 0);
    chk_ctl("ar.rel", 0, 0, 0);
    set_ops(12, 10, 6, 3, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
`ifdef NBA_SEQ_BLOCKING_EN
    chk_regs("ar.run", 2, 10, 10, 1);
`else
    chk_regs("ar.run", 2, 10, 14, 15);
`endif
    chk_ctl("ar.run", 1, 0, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
